avalon_data_master: RTL

Memory-side counterpart to the CPU's decoded MemRead/MemWrite control. The block turns one CPU data-memory request (load/store, size, address, store data) into a single Avalon-MM read or write transaction and handles waitrequest and timeout. It returns the load word and produces the clk_en stall signal that freezes the CPU pipeline until the access completes. It sits between the CPU datapath and the Avalon data bus.

---
 rtl/avalon_data_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/avalon_data_master.sv
// Avalon-MM data master: turns one CPU load/store request into a single
// bus read or write, with waitrequest handling, a timeout, and a CPU stall.
module avalon_data_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        clk_en,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            req, misalign, timeout;
  logic [3:0]      be_lane;
  logic [31:0]     wd_lane;

  assign req     = cpu_read | cpu_write;
  // Last permitted wait cycle: the command is abandoned on this edge.
  assign timeout = avm_waitrequest && (to_cnt == TO_LAST);

  // Alignment check and little-endian lane steering of the store data.
  always_comb begin
    misalign = 1'b0;
    be_lane  = 4'b1111;
    wd_lane  = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_lane = 4'b0001 << cpu_addr[1:0];
        wd_lane = {24'b0, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000};
      end
      2'b01: begin
        misalign = cpu_addr[0];
        be_lane  = 4'b0011 << cpu_addr[1:0];
        wd_lane  = {16'b0, cpu_wdata[15:0]} << {cpu_addr[1:0], 3'b000};
      end
      2'b10:   misalign = (cpu_addr[1:0] != 2'b00);
      default: ;  // size 11: word lanes, alignment forced
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = misalign ? DONE : BUS;
      BUS:     if (!avm_waitrequest || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus command, timeout counter and CPU response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      to_cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cpu_err <= misalign;
          if (!misalign) begin
            avm_address    <= {cpu_addr[31:2], 2'b00};
            avm_byteenable <= be_lane;
            avm_writedata  <= wd_lane;
            // A simultaneous read+write is served as a write.
            avm_write      <= cpu_write;
            avm_read       <= ~cpu_write;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            if (avm_read) cpu_rdata <= avm_readdata;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            cpu_err   <= 1'b0;
          end else if (timeout) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            cpu_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE:    to_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign cpu_ack = (state == DONE);
  assign clk_en  = !(((state == IDLE) && req) || (state == BUS));

endmodule
